stage_mem_wb: RTL and testbench

//  Consumer side of the EXE->MEM pipeline register: data-memory access stage, MEM/WB register and write-back mux.

---
 rtl/stage_mem_wb.sv | 138 +++++++++++++
 tb/tb_stage_mem_wb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem_wb.sv
// MEM stage: wait-stated data memory, MEM/WB pipeline register and write-back mux.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (range-checks accesses and drives addr_err).
module stage_mem_wb #(
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        ready,
  output logic        wb_en_wb,
  output logic [3:0]  dest_wb,
  output logic [31:0] value_wb,
  output logic        addr_err
);

  localparam int unsigned IdxW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic            mem_op, is_load, is_store, complete, in_range;
  logic [31:0]     offset, word_off, rd_data, value_d;
  logic [IdxW-1:0] idx;
  logic [31:0]     mem [MEM_WORDS];

  // A simultaneous read+write request is treated as a store.
  assign mem_op   = mem_read_en_in | mem_write_en_in;
  assign is_store = mem_write_en_in;
  assign is_load  = mem_read_en_in & ~mem_write_en_in;

  assign offset   = alu_res_in - 32'(ADDR_BASE);
  assign word_off = offset >> 2;
  assign idx      = IdxW'(word_off);

`ifdef MEM_BOUNDS_CHECK_EN
  assign in_range = (alu_res_in >= 32'(ADDR_BASE)) && (word_off < 32'(MEM_WORDS));
`else
  assign in_range = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_op && (WaitCnt != 4'd0)) begin
          state_d = StWait;
          cnt_d   = 4'd1;
        end
      end
      StWait: begin
        if (cnt_q == WaitCnt) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  // Output logic; ready is forced high while reset is held
  always_comb begin
    ready = 1'b1;
    if (rst) begin
      unique case (state_q)
        StIdle: ready = ~(mem_op && (WaitCnt != 4'd0));
        StWait: ready = (cnt_q == WaitCnt);
      endcase
    end
  end

  // Gating with rst keeps a store aborted by reset from landing in memory.
  assign complete = ready & rst;

  always_ff @(posedge clk) begin
    if (complete && is_store && in_range) begin
      mem[idx] <= val_rm_in;
    end
  end

  assign rd_data = in_range ? mem[idx] : 32'h0;
  assign value_d = is_load ? rd_data : alu_res_in;

  // MEM/WB register: stall cycles insert a bubble, dest/value hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_wb <= 1'b0;
      dest_wb  <= 4'd0;
      value_wb <= 32'h0;
    end else if (complete) begin
      wb_en_wb <= wb_en_in;
      dest_wb  <= dest_in;
      value_wb <= value_d;
    end else begin
      wb_en_wb <= 1'b0;
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= complete & mem_op & ~in_range;
    end
  end

  assign addr_err = err_q;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_stage_mem_wb.sv
// Bench for stage_mem_wb: directed scenarios followed by randomized traffic against
// a word-array memory model with expected stall counts and write-back values.
module tb_stage_mem_wb;

  localparam int unsigned MW = 64;
  localparam int unsigned AB = 1024;
  localparam int unsigned WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_read_en_in, mem_write_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        ready, wb_en_wb, addr_err;
  logic [3:0]  dest_wb;
  logic [31:0] value_wb;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl   [MW];
  bit          known [MW];

  stage_mem_wb #(
    .MEM_WORDS  (MW),
    .ADDR_BASE  (AB),
    .WAIT_STATES(WS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en_in       (wb_en_in),
    .mem_read_en_in (mem_read_en_in),
    .mem_write_en_in(mem_write_en_in),
    .alu_res_in     (alu_res_in),
    .val_rm_in      (val_rm_in),
    .dest_in        (dest_in),
    .ready          (ready),
    .wb_en_wb       (wb_en_wb),
    .dest_wb        (dest_wb),
    .value_wb       (value_wb),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'(AB)) >> 2;
    return int'(w % MW);
  endfunction

  function automatic bit model_in_range(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    logic [31:0] w;
    w = (a - 32'(AB)) >> 2;
    return (a >= 32'(AB)) && (w < 32'(MW));
`else
    return (a === a);
`endif
  endfunction

  task automatic drive(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] dest, input bit wben);
    mem_read_en_in  = rd;
    mem_write_en_in = wr;
    alu_res_in      = addr;
    val_rm_in       = data;
    dest_in         = dest;
    wb_en_in        = wben;
  endtask

  // Present one transaction, hold it until accepted, then check the write-back.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] dest, input bit wben);
    int          stalls, idx, exp_stalls;
    bit          done, load, ok, val_known, exp_err;
    logic [31:0] exp_val;
    load       = rd & ~wr;
    exp_stalls = (rd | wr) ? int'(WS) : 0;
    idx        = model_idx(addr);
    ok         = model_in_range(addr);
    val_known  = 1'b1;
    if (load) begin
      exp_val   = ok ? mdl[idx] : 32'h0;
      val_known = ok ? known[idx] : 1'b1;
    end else begin
      exp_val = addr;
    end
`ifdef MEM_BOUNDS_CHECK_EN
    exp_err = (rd | wr) & ~ok;
`else
    exp_err = 1'b0;
`endif
    drive(rd, wr, addr, data, dest, wben);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (ready) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
      if (!done) check("bubble_wb_en", {31'd0, wb_en_wb}, 32'd0);
    end
    check("op_completed", {31'd0, done}, 32'd1);
    check("stall_cycles", stalls, exp_stalls);
    check("wb_en_wb", {31'd0, wb_en_wb}, {31'd0, wben});
    check("dest_wb", {28'd0, dest_wb}, {28'd0, dest});
    if (val_known) check("value_wb", value_wb, exp_val);
    check("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
    if (wr && ok) begin
      mdl[idx]   = data;
      known[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] addr;
    int          kind;

    for (int i = 0; i < int'(MW); i++) known[i] = 1'b0;

    // Reset with active inputs
    rst = 1'b0;
    drive(1'b1, 1'b1, 32'd1028, 32'hDEAD, 4'd9, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_wb_en", {31'd0, wb_en_wb}, 32'd0);
    check("rst_dest", {28'd0, dest_wb}, 32'd0);
    check("rst_value", value_wb, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h1234, 32'h0, 4'd5, 1'b1);
    rst = 1'b1;

    // ALU op, then store/load round trip
    do_op(1'b0, 1'b0, 32'h1234, 32'h0, 4'd5, 1'b1);
    do_op(1'b0, 1'b1, 32'd1028, 32'hCAFE, 4'd1, 1'b0);
    do_op(1'b1, 1'b0, 32'd1028, 32'h0, 4'd3, 1'b1);

    // Read+write together is a store
    do_op(1'b1, 1'b1, 32'd1032, 32'd7, 4'd6, 1'b0);
    do_op(1'b1, 1'b0, 32'd1032, 32'h0, 4'd7, 1'b1);

    // Store aborted by reset in its final wait cycle must not land
    do_op(1'b0, 1'b1, 32'd1036, 32'h55, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 32'd1036, 32'hFF, 4'd0, 1'b0);
    repeat (WS) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_wb_en", {31'd0, wb_en_wb}, 32'd0);
    check("abort_value", value_wb, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
    rst = 1'b1;
    do_op(1'b1, 1'b0, 32'd1036, 32'h0, 4'd8, 1'b1);

    // Boundary: one past the last word
    do_op(1'b0, 1'b1, 32'(AB), 32'hA5A5_0001, 4'd0, 1'b0);
    do_op(1'b1, 1'b0, 32'(AB + 4 * MW), 32'h0, 4'd2, 1'b1);
    do_op(1'b1, 1'b0, 32'(AB + 4 * MW - 4), 32'h0, 4'd4, 1'b1);

    // Fill memory, then random traffic
    for (int i = 0; i < int'(MW); i++) begin
      do_op(1'b0, 1'b1, 32'(AB + 4 * i), $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      else addr = 32'(AB) + ($urandom_range(0, 2 * MW - 1) << 2) + $urandom_range(0, 3);
      case (kind)
        0: do_op(1'b0, 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom));
        1: do_op(1'b1, 1'b0, addr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom));
        2: do_op(1'b0, 1'b1, addr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom));
        default: do_op(1'b1, 1'b1, addr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom));
      endcase
    end

    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    check("idle_wb_en", {31'd0, wb_en_wb}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
